otp_xor_stream: RTL and testbench

OTP_XOR_STREAM -- requirements
Module: otp_xor_stream

---
 rtl/otp_xor_stream_pkg.sv | 11 +
 rtl/otp_xor_stream.sv | 84 ++++++++
 tb/tb_otp_xor_stream.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/otp_xor_stream_pkg.sv
// rtl/otp_xor_stream_pkg.sv - shared sizes and FSM encodings for otp_xor_stream
package otp_xor_stream_pkg;

  localparam int MSG_SIZE = 240;
  localparam int KEY_SIZE = 8;

  localparam logic [1:0] OTP_ST_IDLE = 2'd0;
  localparam logic [1:0] OTP_ST_RUN  = 2'd1;
  localparam logic [1:0] OTP_ST_DONE = 2'd2;

endpackage

// File: rtl/otp_xor_stream.sv
// rtl/otp_xor_stream.sv - one-time-pad XOR of a latched message against a streamed key
`ifndef MSG_SIZE
`define MSG_SIZE otp_xor_stream_pkg::MSG_SIZE
`endif
`ifndef KEY_SIZE
`define KEY_SIZE otp_xor_stream_pkg::KEY_SIZE
`endif

module otp_xor_stream
  import otp_xor_stream_pkg::*;
#(
  parameter int MW = `MSG_SIZE,
  parameter int KW = `KEY_SIZE
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [MW-1:0] msg_in,
  input  logic          key_valid,
  input  logic [KW-1:0] key_in,
  output logic          key_req,
  output logic          cipher_valid,
  output logic [KW-1:0] cipher_out,
  input  logic          cipher_ready,
  output logic          busy,
  output logic          done
);

  localparam int N  = MW / KW;
  localparam int IW = $clog2(N + 1);
  localparam logic [IW-1:0] LAST = IW'(N);

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic [MW-1:0] msg;
  logic [KW-1:0] chunk;
  logic          accept;
  logic          out_hs;

  // Chunks are taken MSB first so the first ciphertext byte matches the first message byte.
  assign chunk   = msg[MW - 1 - int'(idx) * KW -: KW];

  assign key_req = (state == OTP_ST_RUN) && (idx < LAST) && (!cipher_valid || cipher_ready);
  assign accept  = key_req && key_valid;
  assign out_hs  = cipher_valid && cipher_ready;
  assign busy    = (state == OTP_ST_RUN);
  assign done    = (state == OTP_ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= OTP_ST_IDLE;
      idx          <= '0;
      msg          <= '0;
      cipher_valid <= 1'b0;
      cipher_out   <= '0;
    end else begin
      case (state)
        OTP_ST_IDLE: begin
          if (start) begin
            msg   <= msg_in;
            idx   <= '0;
            state <= OTP_ST_RUN;
          end
        end
        OTP_ST_RUN: begin
          // Finish only once the final chunk has left the output register.
          if (idx == LAST && (out_hs || !cipher_valid)) begin
            state <= OTP_ST_DONE;
          end
        end
        default: state <= OTP_ST_IDLE;
      endcase

      if (accept) begin
        cipher_out   <= chunk ^ key_in;
        cipher_valid <= 1'b1;
        idx          <= idx + 1'b1;
      end else if (out_hs) begin
        cipher_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_otp_xor_stream.sv
// tb/tb_otp_xor_stream.sv - directed vector bench for otp_xor_stream
module tb_otp_xor_stream;
  import otp_xor_stream_pkg::*;

  localparam int MW = 240;
  localparam int KW = 8;
  localparam int N  = 30;
  localparam logic [MW-1:0] MSG = 240'h48656C6C6F20576F726C6421204120736563726574206D65737361676521;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [MW-1:0] msg_in;
  logic          key_valid;
  logic [KW-1:0] key_in;
  logic          key_req;
  logic          cipher_valid;
  logic [KW-1:0] cipher_out;
  logic          cipher_ready;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  otp_xor_stream #(.MW(MW), .KW(KW)) dut (
    .clk(clk), .rst(rst), .start(start), .msg_in(msg_in),
    .key_valid(key_valid), .key_in(key_in), .key_req(key_req),
    .cipher_valid(cipher_valid), .cipher_out(cipher_out),
    .cipher_ready(cipher_ready), .busy(busy), .done(done)
  );

  typedef struct {
    logic [7:0] key;
    logic [7:0] e_first;
    logic [7:0] e_second;
    logic [7:0] e_last;
  } vec_t;

  vec_t       tbl[4];
  logic [7:0] mb[N];
  logic [7:0] got_q[$];
  int         done_cnt;
  int         n_chk = 0;
  int         n_fail = 0;

  always @(negedge clk) begin
    if (!rst && cipher_valid && cipher_ready) got_q.push_back(cipher_out);
    if (done) done_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_msg(input logic [7:0] k, input bit bp, input bit gaps,
                         input bit busy_start, input string tag);
    int cyc;
    int first_cv;
    bit stalled;
    got_q.delete();
    done_cnt = 0;
    first_cv = -1;
    stalled = 1'b0;
    key_in = k;
    key_valid = 1'b1;
    cipher_ready = 1'b1;
    msg_in = MSG;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, " busy_after_start"}, busy, 1);
    chk({tag, " valid_after_start"}, cipher_valid, 0);
    chk({tag, " key_req_after_start"}, key_req, 1);
    cyc = 0;
    while (!done && cyc < 600) begin
      key_valid = gaps ? (cyc % 2 == 0) : 1'b1;
      if (busy_start) begin
        start  = (cyc >= 4 && cyc < 8);
        msg_in = ~MSG;
      end
      if (bp && !stalled && cipher_valid && got_q.size() == 2) begin
        stalled = 1'b1;
        cipher_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(posedge clk); #1;
          cyc++;
          chk($sformatf("%s stall%0d_out", tag, s), cipher_out, mb[2] ^ k);
          chk($sformatf("%s stall%0d_valid", tag, s), cipher_valid, 1);
          chk($sformatf("%s stall%0d_key_req", tag, s), key_req, 0);
        end
        cipher_ready = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
      if (first_cv < 0 && cipher_valid) first_cv = cyc;
    end
    start = 1'b0;
    msg_in = MSG;
    chk({tag, " finished_in_budget"}, cyc < 600, 1);
    chk({tag, " first_latency"}, first_cv, 1);
    chk({tag, " chunk_count"}, got_q.size(), N);
    for (int i = 0; i < N; i++) begin
      logic [7:0] act;
      act = (i < got_q.size()) ? got_q[i] : 8'hxx;
      chk($sformatf("%s chunk%0d", tag, i), act, mb[i] ^ k);
    end
    @(posedge clk); #1;
    chk({tag, " done_pulses"}, done_cnt, 1);
    chk({tag, " done_low_after"}, done, 0);
    chk({tag, " busy_low_after"}, busy, 0);
  endtask

  initial begin
    logic [MW-1:0] mv;
    int cyc;
    mv = MSG;
    for (int i = 0; i < N; i++) mb[i] = mv[MW - 1 - 8 * i -: 8];

    tbl[0] = '{key: 8'h00, e_first: 8'h48, e_second: 8'h65, e_last: 8'h21};
    tbl[1] = '{key: 8'hFF, e_first: 8'hB7, e_second: 8'h9A, e_last: 8'hDE};
    tbl[2] = '{key: 8'hA5, e_first: 8'hED, e_second: 8'hC0, e_last: 8'h84};
    tbl[3] = '{key: 8'h3C, e_first: 8'h74, e_second: 8'h59, e_last: 8'h1D};

    rst = 1'b1;
    start = 1'b0;
    msg_in = '0;
    key_valid = 1'b0;
    key_in = '0;
    cipher_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset cipher_valid", cipher_valid, 0);
    chk("reset cipher_out", cipher_out, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    key_valid = 1'b1;
    #1;
    chk("reset key_req", key_req, 0);
    rst = 1'b0;

    for (int t = 0; t < 4; t++) begin
      run_msg(tbl[t].key, 1'b0, 1'b0, 1'b0, $sformatf("key%02h", tbl[t].key));
      chk($sformatf("tbl%0d first", t), got_q.size() > 0 ? got_q[0] : 8'hxx, tbl[t].e_first);
      chk($sformatf("tbl%0d second", t), got_q.size() > 1 ? got_q[1] : 8'hxx, tbl[t].e_second);
      chk($sformatf("tbl%0d last", t), got_q.size() > 29 ? got_q[29] : 8'hxx, tbl[t].e_last);
    end

    run_msg(8'hFF, 1'b1, 1'b0, 1'b0, "backpressure");
    run_msg(8'h3C, 1'b0, 1'b1, 1'b0, "key_gaps");
    run_msg(8'hA5, 1'b0, 1'b0, 1'b1, "start_busy");

    got_q.delete();
    key_in = 8'h5A;
    key_valid = 1'b1;
    cipher_ready = 1'b1;
    msg_in = MSG;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (got_q.size() < 10 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("midrst reached_chunk10", got_q.size(), 10);
    chk("midrst busy_before", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst cipher_valid", cipher_valid, 0);
    chk("midrst cipher_out", cipher_out, 0);
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst key_req", key_req, 0);
    chk("midrst msg_reg", dut.msg == '0, 1);
    chk("midrst index", dut.idx, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_msg(8'h00, 1'b0, 1'b0, 1'b0, "restart");
    chk("restart first", got_q.size() > 0 ? got_q[0] : 8'hxx, 8'h48);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
